// File: rtl/adc_uart_responder.sv
// adc_uart_responder: 8N1 UART slave that answers a 0xA1..0xA4 channel query
// with the latched 10-bit ADC sample, sent as a low byte then a high byte.
module adc_uart_responder #(
  parameter int CLKS_PER_BIT = 48,
  parameter int RESP_DELAY   = 96,
  parameter int GAP_BITS     = 1
) (
  input  logic       clk12MHz,
  input  logic       resetn,
  input  logic       rx,
  output logic       tx,
  input  logic [9:0] adc_ch1,
  input  logic [9:0] adc_ch2,
  input  logic [9:0] adc_ch3,
  input  logic [9:0] adc_ch4,
  output logic       busy,
  output logic       cmd_valid,
  output logic [1:0] cmd_channel,
  output logic       err_frame,
  output logic       cmd_ignored
);

  localparam int TMAX = (GAP_BITS * CLKS_PER_BIT > 1023) ? GAP_BITS * CLKS_PER_BIT : 1023;
  localparam int CW   = $clog2(TMAX + 1);
  localparam logic [CW-1:0] CNT_ZERO  = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DLY_LOAD  = CW'(RESP_DELAY - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_BITS * CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    R_IDLE = 3'd0, R_START = 3'd1, R_DATA = 3'd2, R_STOP = 3'd3, R_BREAK = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE = 3'd0, T_DELAY = 3'd1, T_LO = 3'd2, T_GAP = 3'd3, T_HI = 3'd4
  } tx_state_t;

  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic [9:0] frame;
    frame = {1'b1, data, 1'b0};
    return frame[idx];
  endfunction

  logic            rx_meta_r, rx_sync_r, rx_prev_r;
  rx_state_t       r_state_r, r_state_s;
  logic [CW-1:0]   r_cnt_r, r_cnt_s;
  logic [2:0]      r_bits_r, r_bits_s;
  logic [7:0]      r_shift_r, r_shift_s;
  logic            frame_ok_s, frame_err_s;
  tx_state_t       t_state_r, t_state_s;
  logic [CW-1:0]   t_cnt_r, t_cnt_s;
  logic [3:0]      t_bit_r, t_bit_s;
  logic            tx_r, tx_s, tx_done_s;
  logic [7:0]      tx_byte_s;
  logic            cmd_valid_r, cmd_ignored_r, err_frame_r, busy_r;
  logic [1:0]      cmd_channel_r, cmd_ch_s;
  logic [9:0]      hold_r, sample_s;
  logic            is_cmd_s, accept_s;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk12MHz or negedge resetn) begin
    if (!resetn) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= rx;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // Receiver next-state: sample each bit at its centre, reject short start glitches.
  always_comb begin
    r_state_s   = r_state_r;
    r_cnt_s     = r_cnt_r;
    r_bits_s    = r_bits_r;
    r_shift_s   = r_shift_r;
    frame_ok_s  = 1'b0;
    frame_err_s = 1'b0;
    case (r_state_r)
      R_IDLE: begin
        if (rx_prev_r && !rx_sync_r) begin
          r_state_s = R_START;
          r_cnt_s   = HALF_LOAD;
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_START: begin
        if (r_cnt_r != CNT_ZERO) begin
          r_cnt_s = r_cnt_r - CNT_ONE;
        end else if (!rx_sync_r) begin
          r_state_s = R_DATA;
          r_cnt_s   = BIT_LOAD;
          r_bits_s  = 3'd0;
        end else begin
          r_state_s = R_IDLE;
        end
      end
      R_DATA: begin
        if (r_cnt_r != CNT_ZERO) begin
          r_cnt_s = r_cnt_r - CNT_ONE;
        end else begin
          r_shift_s = {rx_sync_r, r_shift_r[7:1]};
          r_cnt_s   = BIT_LOAD;
          if (r_bits_r == 3'd7) begin
            r_state_s = R_STOP;
          end else begin
            r_bits_s = r_bits_r + 3'd1;
          end
        end
      end
      R_STOP: begin
        if (r_cnt_r != CNT_ZERO) begin
          r_cnt_s = r_cnt_r - CNT_ONE;
        end else if (rx_sync_r) begin
          frame_ok_s = 1'b1;
          r_state_s  = R_IDLE;
        end else begin
          frame_err_s = 1'b1;
          r_state_s   = R_BREAK;
        end
      end
      R_BREAK: begin
        if (rx_sync_r) begin
          r_state_s = R_IDLE;
        end else begin
          r_state_s = R_BREAK;
        end
      end
      default: r_state_s = R_IDLE;
    endcase
  end

  // Receiver state registers.
  always_ff @(posedge clk12MHz or negedge resetn) begin
    if (!resetn) begin
      r_state_r <= R_IDLE;
      r_cnt_r   <= CNT_ZERO;
      r_bits_r  <= 3'd0;
      r_shift_r <= 8'h00;
    end else begin
      r_state_r <= r_state_s;
      r_cnt_r   <= r_cnt_s;
      r_bits_r  <= r_bits_s;
      r_shift_r <= r_shift_s;
    end
  end

  assign is_cmd_s = (r_shift_r >= 8'hA1) && (r_shift_r <= 8'hA4);
  assign accept_s = frame_ok_s && is_cmd_s && !busy_r;
  assign cmd_ch_s = r_shift_r[1:0] - 2'd1;

  // Channel sample mux for the hold register.
  always_comb begin
    sample_s = adc_ch1;
    case (cmd_ch_s)
      2'd0:    sample_s = adc_ch1;
      2'd1:    sample_s = adc_ch2;
      2'd2:    sample_s = adc_ch3;
      2'd3:    sample_s = adc_ch4;
      default: sample_s = adc_ch1;
    endcase
  end

  // Command decode: status pulses, sample latch and busy tracking.
  always_ff @(posedge clk12MHz or negedge resetn) begin
    if (!resetn) begin
      cmd_valid_r   <= 1'b0;
      cmd_ignored_r <= 1'b0;
      err_frame_r   <= 1'b0;
      cmd_channel_r <= 2'd0;
      hold_r        <= 10'd0;
      busy_r        <= 1'b0;
    end else begin
      cmd_valid_r   <= accept_s;
      cmd_ignored_r <= frame_ok_s && !accept_s;
      err_frame_r   <= frame_err_s;
      if (accept_s) begin
        cmd_channel_r <= cmd_ch_s;
        hold_r        <= sample_s;
        busy_r        <= 1'b1;
      end else if (tx_done_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  assign tx_byte_s = (t_state_r == T_HI) ? {6'b000000, hold_r[9:8]} : hold_r[7:0];

  // Transmitter next-state: tx is registered, so each bit value is set on entry.
  always_comb begin
    t_state_s = t_state_r;
    t_cnt_s   = t_cnt_r;
    t_bit_s   = t_bit_r;
    tx_s      = tx_r;
    tx_done_s = 1'b0;
    case (t_state_r)
      T_IDLE: begin
        tx_s = 1'b1;
        if (cmd_valid_r) begin
          t_state_s = T_DELAY;
          t_cnt_s   = DLY_LOAD;
        end else begin
          t_state_s = T_IDLE;
        end
      end
      T_DELAY: begin
        if (t_cnt_r != CNT_ZERO) begin
          t_cnt_s = t_cnt_r - CNT_ONE;
        end else begin
          t_state_s = T_LO;
          t_bit_s   = 4'd0;
          t_cnt_s   = BIT_LOAD;
          tx_s      = 1'b0;
        end
      end
      T_LO, T_HI: begin
        if (t_cnt_r != CNT_ZERO) begin
          t_cnt_s = t_cnt_r - CNT_ONE;
        end else if (t_bit_r != 4'd9) begin
          t_bit_s = t_bit_r + 4'd1;
          t_cnt_s = BIT_LOAD;
          tx_s    = frame_bit(tx_byte_s, t_bit_r + 4'd1);
        end else if (t_state_r == T_HI) begin
          t_state_s = T_IDLE;
          tx_s      = 1'b1;
          tx_done_s = 1'b1;
        end else if (GAP_BITS == 0) begin
          t_state_s = T_HI;
          t_bit_s   = 4'd0;
          t_cnt_s   = BIT_LOAD;
          tx_s      = 1'b0;
        end else begin
          t_state_s = T_GAP;
          t_cnt_s   = GAP_LOAD;
          tx_s      = 1'b1;
        end
      end
      T_GAP: begin
        if (t_cnt_r != CNT_ZERO) begin
          t_cnt_s = t_cnt_r - CNT_ONE;
        end else begin
          t_state_s = T_HI;
          t_bit_s   = 4'd0;
          t_cnt_s   = BIT_LOAD;
          tx_s      = 1'b0;
        end
      end
      default: begin
        t_state_s = T_IDLE;
        tx_s      = 1'b1;
      end
    endcase
  end

  // Transmitter state registers.
  always_ff @(posedge clk12MHz or negedge resetn) begin
    if (!resetn) begin
      t_state_r <= T_IDLE;
      t_cnt_r   <= CNT_ZERO;
      t_bit_r   <= 4'd0;
      tx_r      <= 1'b1;
    end else begin
      t_state_r <= t_state_s;
      t_cnt_r   <= t_cnt_s;
      t_bit_r   <= t_bit_s;
      tx_r      <= tx_s;
    end
  end

  assign tx          = tx_r;
  assign busy        = busy_r;
  assign cmd_valid   = cmd_valid_r;
  assign cmd_ignored = cmd_ignored_r;
  assign err_frame   = err_frame_r;
  assign cmd_channel = cmd_channel_r;

endmodule

// File: tb/tb_adc_uart_responder.sv
// Scoreboard bench for adc_uart_responder: stimulus queues expected pulses and
// tx bytes; independent monitors compare what the DUT produces.
module tb_adc_uart_responder;

  localparam int CPB = 48;
  localparam int DLY = 96;
  localparam int GAP = 1;
  localparam logic [1:0] EV_VALID = 2'd1;
  localparam logic [1:0] EV_IGN   = 2'd2;
  localparam logic [1:0] EV_ERR   = 2'd3;

  typedef struct packed { logic [1:0] code; logic [1:0] ch; } ev_t;
  typedef struct packed { logic [7:0] data; logic hi; } txe_t;

  logic       clk12MHz = 1'b0;
  logic       resetn = 1'b0;
  logic       rx = 1'b1;
  logic [9:0] adc_ch1 = 10'd0, adc_ch2 = 10'd0, adc_ch3 = 10'd0, adc_ch4 = 10'd0;
  logic       tx, busy, cmd_valid, err_frame, cmd_ignored;
  logic [1:0] cmd_channel;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int cv_cycle = 0;
  int lo_start = 0;
  ev_t  ev_q[$];
  txe_t tx_q[$];

  adc_uart_responder #(.CLKS_PER_BIT(CPB), .RESP_DELAY(DLY), .GAP_BITS(GAP)) dut (
    .clk12MHz(clk12MHz), .resetn(resetn), .rx(rx), .tx(tx),
    .adc_ch1(adc_ch1), .adc_ch2(adc_ch2), .adc_ch3(adc_ch3), .adc_ch4(adc_ch4),
    .busy(busy), .cmd_valid(cmd_valid), .cmd_channel(cmd_channel),
    .err_frame(err_frame), .cmd_ignored(cmd_ignored)
  );

  always #5 clk12MHz = ~clk12MHz;
  always @(posedge clk12MHz) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic push_resp(input logic [1:0] ch, input logic [9:0] sample);
    ev_q.push_back('{code: EV_VALID, ch: ch});
    tx_q.push_back('{data: sample[7:0], hi: 1'b0});
    tx_q.push_back('{data: {6'b000000, sample[9:8]}, hi: 1'b1});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx = fr[i];
      repeat (CPB) @(posedge clk12MHz);
      #1;
    end
    rx = 1'b1;
  endtask

  function automatic bit cond_met(input int which);
    case (which)
      0:       return busy == 1'b0;
      1:       return tx == 1'b0;
      2:       return cmd_valid == 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_until(input int which, input int limit, input string name);
    int n;
    n = 0;
    while (!cond_met(which) && n < limit) begin
      @(negedge clk12MHz);
      n++;
    end
    check(name, int'(cond_met(which)), 1);
  endtask

  task automatic expect_event(input logic [1:0] code, input logic [1:0] ch);
    ev_t e;
    if (ev_q.size() == 0) begin
      check("unexpected_event_queue", ev_q.size(), 1);
    end else begin
      e = ev_q.pop_front();
      check("event_code", code, e.code);
      if (code == EV_VALID) check("cmd_channel", ch, e.ch);
    end
  endtask

  // Pulse monitor
  initial forever begin
    @(negedge clk12MHz);
    if (resetn) begin
      if (cmd_valid) begin
        cv_cycle = cyc;
        expect_event(EV_VALID, cmd_channel);
      end
      if (cmd_ignored) expect_event(EV_IGN, 2'd0);
      if (err_frame)   expect_event(EV_ERR, 2'd0);
    end
  end

  // Serial tx monitor: checks every cycle of each frame against the expected byte
  txe_t       m_e;
  logic [9:0] m_fr;
  logic [7:0] m_got;
  int         m_errs;
  bit         m_abort;
  logic       m_busy_last;
  initial forever begin
    @(negedge clk12MHz);
    if (resetn && tx === 1'b0) begin
      if (tx_q.size() == 0) begin
        check("unexpected_tx_frame_queue", tx_q.size(), 1);
        repeat (10 * CPB) @(negedge clk12MHz);
      end else begin
        m_e = tx_q.pop_front();
        m_fr = {1'b1, m_e.data, 1'b0};
        m_errs = 0;
        m_got = 8'h00;
        m_abort = 1'b0;
        m_busy_last = 1'b0;
        if (!m_e.hi) begin
          check("resp_start_delay", cyc - cv_cycle, DLY + 1);
          lo_start = cyc;
        end else begin
          check("hi_start_spacing", cyc - lo_start, 10 * CPB + GAP * CPB);
        end
        for (int i = 0; i < 10 * CPB; i++) begin
          if (i > 0) @(negedge clk12MHz);
          if (!resetn) begin
            m_abort = 1'b1;
            break;
          end
          if (tx !== m_fr[i / CPB]) m_errs++;
          if ((i % CPB) == CPB / 2 && i / CPB >= 1 && i / CPB <= 8) m_got[i / CPB - 1] = tx;
          m_busy_last = busy;
        end
        if (!m_abort) begin
          check("tx_byte", m_got, m_e.data);
          check("tx_bit_timing_errs", m_errs, 0);
          if (m_e.hi) begin
            check("busy_in_last_stop", m_busy_last, 1);
            @(negedge clk12MHz);
            check("busy_after_stop", busy, 0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  logic [7:0] ign_bytes [3];

  initial begin
    ign_bytes = '{8'h55, 8'hA0, 8'hA5};
    repeat (3) @(negedge clk12MHz);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_cmd_valid", cmd_valid, 0);
    check("rst_err_frame", err_frame, 0);
    check("rst_cmd_ignored", cmd_ignored, 0);
    check("rst_cmd_channel", cmd_channel, 0);
    resetn = 1'b1;
    repeat (10) @(negedge clk12MHz);

    // Channel 1 query
    adc_ch1 = 10'h2B5;
    push_resp(2'd0, 10'h2B5);
    send_byte(8'hA1, 1'b1);
    wait_until(0, 1500, "t1_busy_release");
    repeat (5) @(negedge clk12MHz);

    // Channel 4 query with the input changing after the latch
    adc_ch4 = 10'h3FF;
    push_resp(2'd3, 10'h3FF);
    fork
      send_byte(8'hA4, 1'b1);
      begin
        wait_until(2, 800, "t2_cmd_valid_seen");
        @(posedge clk12MHz);
        #1 adc_ch4 = 10'h000;
      end
    join
    wait_until(0, 1500, "t2_busy_release");
    repeat (5) @(negedge clk12MHz);

    // Non-command bytes
    for (int i = 0; i < 3; i++) begin
      ev_q.push_back('{code: EV_IGN, ch: 2'd0});
      send_byte(ign_bytes[i], 1'b1);
      check("ign_tx_idle", tx, 1);
      check("ign_busy_low", busy, 0);
    end

    // Framing error then a short glitch
    ev_q.push_back('{code: EV_ERR, ch: 2'd0});
    send_byte(8'hA2, 1'b0);
    repeat (10) @(negedge clk12MHz);
    rx = 1'b0;
    repeat (20) @(posedge clk12MHz);
    rx = 1'b1;
    repeat (100) @(negedge clk12MHz);
    check("err_tx_idle", tx, 1);
    check("err_busy_low", busy, 0);

    // Query while busy is ignored
    adc_ch3 = 10'h155;
    push_resp(2'd2, 10'h155);
    send_byte(8'hA3, 1'b1);
    wait_until(1, 300, "t5_tx_start");
    ev_q.push_back('{code: EV_IGN, ch: 2'd0});
    send_byte(8'hA1, 1'b1);
    wait_until(0, 1500, "t5_busy_release");
    repeat (5) @(negedge clk12MHz);

    // Reset mid low byte, then a fresh query
    adc_ch1 = 10'h2B5;
    push_resp(2'd0, 10'h2B5);
    send_byte(8'hA1, 1'b1);
    wait_until(1, 300, "t6_tx_start");
    repeat (10) @(negedge clk12MHz);
    check("t6_tx_low_before_reset", tx, 0);
    #2 resetn = 1'b0;
    #1;
    check("t6_reset_tx_high", tx, 1);
    check("t6_reset_busy_low", busy, 0);
    repeat (5) @(negedge clk12MHz);
    tx_q.delete();
    ev_q.delete();
    resetn = 1'b1;
    repeat (10) @(negedge clk12MHz);
    adc_ch1 = 10'h0C3;
    push_resp(2'd0, 10'h0C3);
    send_byte(8'hA1, 1'b1);
    wait_until(0, 1500, "t6_busy_release");
    repeat (5) @(negedge clk12MHz);

    check("event_queue_drained", ev_q.size(), 0);
    check("tx_queue_drained", tx_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_uart_responder.md
Name: adc_uart_responder

Overview:
- UART responder for the 250 kbaud ADC query protocol: receives a one-byte channel request and answers with the 10-bit sample as two bytes.
- Stands in for the on-board ADC controller as a loop-back partner and simulation model for the FPGA-side initiator; sits between the serial rx/tx pins and four 10-bit sample inputs.
- Frame format: 8N1, LSB first, idle high.

Parameters:
- CLKS_PER_BIT, 48, clk12MHz cycles per bit (12 MHz / 250 kbaud)
- RESP_DELAY, 96, idle cycles from command stop-bit sample to response start bit
- GAP_BITS, 1, extra idle-high bit times between the low and high response bytes

Ports:
- clk12MHz  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- rx  in  1  serial input from initiator (asynchronous to clk12MHz)
- tx  out  1  serial output to initiator
- adc_ch1  in  10  channel 1 sample; adc_ch2, adc_ch3, adc_ch4 identical for channels 2-4
- busy  out  1  high from accepted command until the last response stop bit ends
- cmd_valid  out  1  one-cycle pulse on an accepted command
- cmd_channel  out  2  channel of last accepted command (0 = ch1 .. 3 = ch4)
- err_frame  out  1  one-cycle pulse on a framing error
- cmd_ignored  out  1  one-cycle pulse on a valid frame that is not accepted

Behaviour:
- Reset (async assert, synchronous release):
  - tx=1; busy=0; cmd_valid=0; err_frame=0; cmd_ignored=0; cmd_channel=0.
  - Both FSMs go to IDLE. Reset mid-frame aborts immediately; tx returns high without finishing the byte.
- rx synchroniser: two flops; all decoding uses the synchronised signal, which lags the pin by 2 cycles.
- Receiver FSM: R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE.
  - R_IDLE: a falling edge of synchronised rx loads the bit counter with CLKS_PER_BIT/2-1 and enters R_START.
  - R_START: at count 0, if rx is still 0, enter R_DATA with count CLKS_PER_BIT-1; if rx is 1 it is a glitch: return to R_IDLE with no pulse.
  - R_DATA: sample at each count 0, shifting LSB first; 8 samples, then R_STOP.
  - R_STOP: sample at count 0 (mid stop bit).
    - 1: frame valid.
    - 0: err_frame pulse, byte discarded, wait for rx=1 before returning to R_IDLE.
- Command decode on a valid frame:
  - Byte 0xA1..0xA4 with busy=0 is accepted:
    - Latch the matching adc_chN into a 10-bit hold register in the same cycle.
    - cmd_channel = byte-0xA1; pulse cmd_valid; busy=1.
  - Any other byte, or any byte while busy=1, pulses cmd_ignored and is otherwise discarded.
  - The receiver keeps running while transmitting (full duplex).
- Transmit FSM: T_IDLE -> T_DELAY -> T_LO -> T_GAP -> T_HI -> T_IDLE.
  - T_DELAY: counts RESP_DELAY cycles, starting the cycle after cmd_valid.
  - T_LO: sends hold[7:0]. Each bit is held exactly CLKS_PER_BIT cycles: start 0, 8 data bits LSB first, stop 1. A frame is 10*CLKS_PER_BIT cycles.
  - T_GAP: tx=1 for GAP_BITS*CLKS_PER_BIT cycles. GAP_BITS=0 goes straight to T_HI.
  - T_HI: sends {6'b0, hold[9:8]} in the same frame format.
  - busy falls in the cycle after the last stop-bit cycle of T_HI.
- Timing:
  - The first tx low cycle begins exactly RESP_DELAY+1 cycles after cmd_valid.
  - Total response duration: (20+GAP_BITS)*CLKS_PER_BIT cycles.
- Sample stability: the response always uses the latched hold value; adc_chN changes after latch have no effect.
- Counter widths: sized for CLKS_PER_BIT and RESP_DELAY up to 1023. A counter reloads on reaching 0 and never wraps through the maximum value.

Test Plan:
- Send 0xA1 with adc_ch1=0x2B5 -> cmd_valid, cmd_channel=0; tx emits 0xB5 then 0x02; start edge at RESP_DELAY+1 cycles; every bit exactly 48 cycles; low stop bit to high start bit spaced 48 cycles idle.
- Send 0xA4 with adc_ch4=0x3FF, change adc_ch4 to 0x000 one cycle after cmd_valid -> response 0xFF, 0x03; cmd_channel=3.
- Send 0x55, then 0xA0, then 0xA5 -> three cmd_ignored pulses; tx stays 1; busy stays 0.
- Send 0xA2 with stop bit forced 0 -> err_frame pulse, no cmd_valid, tx idle. A following rx low pulse of 20 cycles (below half bit) -> no frame, no pulses.
- Send 0xA3 (adc_ch3=0x155), then 0xA1 during T_LO -> second byte gives cmd_ignored; response stays 0x55, 0x01; busy drops after the final stop bit.
- Assert resetn low mid-T_LO while tx=0 -> tx=1 and busy=0 within the same cycle; after release a new 0xA1 is answered normally.
